// File: rtl/camera_reg_sequencer.sv
// Sequences the image-sensor register writes: a full init table after reset or soft
// reset, then incremental updates of only those configuration values that changed.
module camera_reg_sequencer #(
  parameter logic [7:0]  SLAVE_ADDR = 8'hBA,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] start_row,
  input  logic [15:0] start_column,
  input  logic [15:0] row_size,
  input  logic [15:0] column_size,
  input  logic [15:0] row_mode,
  input  logic [15:0] column_mode,
  input  logic [15:0] exposure,
  input  logic        cam_soft_reset_n,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_dev,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  input  logic        cmd_done,
  input  logic        cmd_nack,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] cfg_in [7];
  logic [15:0] shadow [7];
  logic [6:0]  dirty;
  logic [6:0]  diff;
  logic [6:0]  clr;
  logic        init_pending;
  logic        full_seq;
  logic        abort;
  logic [3:0]  ptr;
  logic [3:0]  sel_idx;
  logic        sel_found;
  logic [8:0]  want;
  logic [7:0]  sel_addr;
  logic [15:0] sel_data;
  logic [7:0]  retry_cnt;

  // Entries E2..E8 map onto cfg_in[0..6] and their shadows/dirty bits.
  assign cfg_in[0] = start_row;
  assign cfg_in[1] = start_column;
  assign cfg_in[2] = row_size;
  assign cfg_in[3] = column_size;
  assign cfg_in[4] = row_mode;
  assign cfg_in[5] = column_mode;
  assign cfg_in[6] = exposure;

  assign cmd_dev   = SLAVE_ADDR;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_comb begin
    diff = '0;
    clr  = '0;
    for (int k = 0; k < 7; k++) begin
      diff[k] = (cfg_in[k] != shadow[k]);
      if (sel_idx == 4'(k + 2)) clr[k] = 1'b1;
    end
  end

  // Lowest candidate at or above ptr; a full sequence takes every entry.
  always_comb begin
    want      = full_seq ? 9'h1FF : {dirty, 2'b00};
    sel_found = 1'b0;
    sel_idx   = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (want[i] && (4'(i) >= ptr)) begin
        sel_found = 1'b1;
        sel_idx   = 4'(i);
      end
    end
  end

  always_comb begin
    sel_addr = 8'h00;
    sel_data = 16'h0000;
    case (sel_idx)
      4'd0: begin sel_addr = 8'h0D; sel_data = 16'h0001;  end
      4'd1: begin sel_addr = 8'h0D; sel_data = 16'h0000;  end
      4'd2: begin sel_addr = 8'h01; sel_data = cfg_in[0]; end
      4'd3: begin sel_addr = 8'h02; sel_data = cfg_in[1]; end
      4'd4: begin sel_addr = 8'h03; sel_data = cfg_in[2]; end
      4'd5: begin sel_addr = 8'h04; sel_data = cfg_in[3]; end
      4'd6: begin sel_addr = 8'h22; sel_data = cfg_in[4]; end
      4'd7: begin sel_addr = 8'h23; sel_data = cfg_in[5]; end
      4'd8: begin sel_addr = 8'h09; sel_data = cfg_in[6]; end
      default: begin sel_addr = 8'h00; sel_data = 16'h0000; end
    endcase
  end

  // Command handshake: a write transfers on the rising edge where cmd_valid and
  // cmd_ready are both high; cmd_addr/cmd_data hold steady while cmd_valid waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cmd_valid    <= 1'b0;
      cmd_addr     <= 8'h00;
      cmd_data     <= 16'h0000;
      cfg_done     <= 1'b0;
      cfg_error    <= 1'b0;
      retry_cnt    <= 8'd0;
      init_pending <= 1'b1;
      full_seq     <= 1'b0;
      abort        <= 1'b0;
      ptr          <= 4'd0;
      dirty        <= 7'd0;
      for (int k = 0; k < 7; k++) shadow[k] <= cfg_in[k];
    end else begin
      cfg_done <= 1'b0;
      dirty    <= dirty | diff;
      if (!cam_soft_reset_n) init_pending <= 1'b1;
      case (state)
        S_IDLE: begin
          if (cam_soft_reset_n && (init_pending || (|dirty))) begin
            state        <= S_SELECT;
            ptr          <= 4'd0;
            full_seq     <= init_pending;
            init_pending <= 1'b0;
          end
        end
        S_SELECT: begin
          if (!cam_soft_reset_n) begin
            state <= S_IDLE;
          end else if (sel_found) begin
            cmd_addr  <= sel_addr;
            cmd_data  <= sel_data;
            cmd_valid <= 1'b1;
            retry_cnt <= 8'd0;
            ptr       <= sel_idx + 4'd1;
            dirty     <= (dirty | diff) & ~clr;
            for (int k = 0; k < 7; k++) begin
              if (clr[k]) shadow[k] <= cfg_in[k];
            end
            state <= S_ISSUE;
          end else begin
            cfg_done <= 1'b1;
            state    <= S_FINISH;
          end
        end
        S_ISSUE: begin
          // An accepted command must still be waited out, even if soft reset arrives.
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            abort     <= !cam_soft_reset_n;
            state     <= S_WAIT;
          end else if (!cam_soft_reset_n) begin
            cmd_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (!cam_soft_reset_n) abort <= 1'b1;
          if (cmd_done) begin
            if (abort || !cam_soft_reset_n) begin
              abort <= 1'b0;
              state <= S_IDLE;
            end else if (!cmd_nack) begin
              state <= S_SELECT;
            end else if (retry_cnt < 8'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 8'd1;
              cmd_valid <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              cfg_error <= 1'b1;
              state     <= S_SELECT;
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_reg_sequencer.sv
// Bench for camera_reg_sequencer: an I2C-master responder, a register-image model of
// the sensor, vector table, randomized updates and directed abort/retry sequences.
module tb_camera_reg_sequencer;

  localparam logic [7:0] DEV = 8'hBA;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] cfg_v [7];
  logic [15:0] start_row, start_column, row_size, column_size;
  logic [15:0] row_mode, column_mode, exposure;
  logic        cam_soft_reset_n;
  logic        cmd_valid, cmd_ready, cmd_done, cmd_nack;
  logic [7:0]  cmd_dev, cmd_addr;
  logic [15:0] cmd_data;
  logic        busy, cfg_done, cfg_error;
  logic [2:0]  dbg_state;

  assign start_row    = cfg_v[0];
  assign start_column = cfg_v[1];
  assign row_size     = cfg_v[2];
  assign column_size  = cfg_v[3];
  assign row_mode     = cfg_v[4];
  assign column_mode  = cfg_v[5];
  assign exposure     = cfg_v[6];

  camera_reg_sequencer #(.SLAVE_ADDR(8'hBA), .MAX_RETRY(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .start_row        (start_row),
    .start_column     (start_column),
    .row_size         (row_size),
    .column_size      (column_size),
    .row_mode         (row_mode),
    .column_mode      (column_mode),
    .exposure         (exposure),
    .cam_soft_reset_n (cam_soft_reset_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_dev          (cmd_dev),
    .cmd_addr         (cmd_addr),
    .cmd_data         (cmd_data),
    .cmd_done         (cmd_done),
    .cmd_nack         (cmd_nack),
    .busy             (busy),
    .cfg_done         (cfg_done),
    .cfg_error        (cfg_error),
    .dbg_state        (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;
  int stab_err  = 0;
  int tgt       = 0;

  int          ready_mode = 0;     // 0: always ready, 1: random, 2: never ready
  int          done_delay = 1;
  int          pend       = -1;
  logic [7:0]  nack_addr  = 8'hFF;
  logic        nack_now   = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [23:0] prev_cmd   = '0;

  logic [31:0] got_q [$];
  logic [31:0] exp_q [$];
  logic [15:0] img [7];
  logic [7:0]  addr_tab [7];

  typedef struct {
    int          idx;
    logic [15:0] val;
    logic [7:0]  exp_addr;
  } vec_t;
  vec_t vecs [8];

  // ---------------- I2C master responder + monitor ----------------
  initial begin
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    cmd_nack  = 1'b0;
    forever begin
      @(negedge clk);
      // What the DUT did at the last rising edge, given what it saw there.
      if (prev_valid && cam_soft_reset_n && !reset) begin
        if (prev_ready) begin
          if (cmd_valid) stab_err++;
        end else if (!cmd_valid || ({cmd_addr, cmd_data} != prev_cmd)) begin
          stab_err++;
        end
      end
      if (cfg_done) done_cnt++;
      cmd_done = 1'b0;
      cmd_nack = 1'b0;
      if (reset) pend = -1;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          cmd_done = 1'b1;
          cmd_nack = nack_now;
          pend     = -1;
        end
      end
      case (ready_mode)
        0:       cmd_ready = 1'b1;
        1:       cmd_ready = 1'($urandom_range(0, 1));
        default: cmd_ready = 1'b0;
      endcase
      if (cmd_valid && cmd_ready && !reset) begin
        got_q.push_back({cmd_dev, cmd_addr, cmd_data});
        pend     = done_delay;
        nack_now = (cmd_addr == nack_addr);
      end
      prev_valid = cmd_valid;
      prev_ready = cmd_ready;
      prev_cmd   = {cmd_addr, cmd_data};
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Sensor register image model: what each entry should carry on the wire.
  task automatic push_entry(input int e);
    if (e == 0)      exp_q.push_back({DEV, 8'h0D, 16'h0001});
    else if (e == 1) exp_q.push_back({DEV, 8'h0D, 16'h0000});
    else begin
      exp_q.push_back({DEV, addr_tab[e-2], cfg_v[e-2]});
      img[e-2] = cfg_v[e-2];
    end
  endtask

  task automatic expect_full();
    for (int e = 0; e < 9; e++) push_entry(e);
  endtask

  task automatic expect_update(output int n);
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if (cfg_v[i] != img[i]) begin
        push_entry(i + 2);
        n++;
      end
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int c = 0;
    while (done_cnt < target && c < budget) begin
      tick(1);
      c++;
    end
    tick(2);
    chk("cfg_done_count", 32'(done_cnt), 32'(target));
    chk("busy_after_seq", 32'(busy), 32'd0);
  endtask

  task automatic wait_log(input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    chk("log_reach", 32'(got_q.size()), 32'(n));
  endtask

  task automatic check_log(input string name);
    int n;
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(name, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic soft_pulse();
    cam_soft_reset_n = 1'b0;
    tick(3);
    chk("soft_low_idle", 32'(busy), 32'd0);
    cam_soft_reset_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [15:0] hold_val;

    addr_tab = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h22, 8'h23, 8'h09};
    vecs[0] = '{0, 16'h0010, 8'h01};
    vecs[1] = '{1, 16'h0280, 8'h02};
    vecs[2] = '{2, 16'h01E0, 8'h03};
    vecs[3] = '{3, 16'h0500, 8'h04};
    vecs[4] = '{4, 16'h0003, 8'h22};
    vecs[5] = '{5, 16'h0030, 8'h23};
    vecs[6] = '{6, 16'h1234, 8'h09};
    vecs[7] = '{0, 16'h0011, 8'h01};

    cfg_v = '{16'h0014, 16'h0040, 16'h03BF, 16'h04FF, 16'h0000, 16'h0000, 16'h0100};
    reset            = 1'b1;
    cam_soft_reset_n = 1'b1;
    tick(3);

    // Reset state
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_cfg_done",  32'(cfg_done),  32'd0);
    chk("rst_cfg_error", 32'(cfg_error), 32'd0);
    chk("rst_cmd_addr",  32'(cmd_addr),  32'd0);
    chk("rst_cmd_data",  32'(cmd_data),  32'd0);
    chk("rst_cmd_dev",   32'(cmd_dev),   32'hBA);

    // Full sequence straight out of reset
    reset = 1'b0;
    tick(1);
    chk("leave_idle_after_reset", 32'(busy), 32'd1);
    expect_full();
    tgt++;
    wait_done(tgt, 400);
    check_log("full_after_reset");
    chk("no_error_full", 32'(cfg_error), 32'd0);

    // Two inputs changing together: ascending index order
    cfg_v[6] = 16'h0400;
    cfg_v[4] = 16'h0011;
    exp_q.push_back({DEV, 8'h22, 16'h0011});
    exp_q.push_back({DEV, 8'h09, 16'h0400});
    img[4] = 16'h0011;
    img[6] = 16'h0400;
    tgt++;
    wait_done(tgt, 200);
    check_log("two_changes");

    // Vector table: one input per record, one command expected
    for (int v = 0; v < 8; v++) begin
      cfg_v[vecs[v].idx] = vecs[v].val;
      exp_q.push_back({DEV, vecs[v].exp_addr, vecs[v].val});
      img[vecs[v].idx] = vecs[v].val;
      tgt++;
      wait_done(tgt, 200);
      check_log("vector");
    end

    // Back-pressure: command held stable while cmd_ready stays low
    ready_mode = 2;
    hold_val   = img[2] ^ 16'hA5A5;
    cfg_v[2]   = hold_val;
    expect_update(n);
    for (int c = 0; c < 20 && !cmd_valid; c++) tick(1);
    for (int c = 0; c < 10; c++) begin
      chk("hold_valid", 32'(cmd_valid), 32'd1);
      chk("hold_addr",  32'(cmd_addr),  32'h03);
      chk("hold_data",  32'(cmd_data),  32'(hold_val));
      tick(1);
    end
    ready_mode = 0;
    tgt++;
    wait_done(tgt, 200);
    check_log("backpressure");

    // Randomized updates against the register-image model
    for (int it = 0; it < 20; it++) begin
      ready_mode = $urandom_range(0, 1);
      done_delay = $urandom_range(1, 3);
      for (int i = 0; i < 7; i++) begin
        if ($urandom_range(0, 2) == 0)
          cfg_v[i] = ($urandom_range(0, 3) == 0) ? cfg_v[i] : 16'($urandom);
      end
      expect_update(n);
      if (n == 0) begin
        tick(6);
        chk("rand_idle_busy", 32'(busy), 32'd0);
      end else begin
        tgt++;
        wait_done(tgt, 600);
      end
      check_log("rand");
    end
    ready_mode = 0;
    done_delay = 1;

    // start_column changes one cycle after E3's handshake
    soft_pulse();
    expect_full();
    wait_log(4, 200);
    tick(1);
    cfg_v[1] = 16'h0020;
    expect_update(n);
    tgt += 2;
    wait_done(tgt, 400);
    check_log("col_change");

    // Soft reset while waiting on E3: no further command, then a full restart
    done_delay = 4;
    soft_pulse();
    for (int e = 0; e < 4; e++) push_entry(e);
    wait_log(4, 200);
    tick(1);
    cam_soft_reset_n = 1'b0;
    tick(12);
    chk("abort_idle",       32'(busy),         32'd0);
    chk("abort_no_new_cmd", 32'(got_q.size()), 32'd4);
    chk("abort_no_done",    32'(done_cnt),     32'(tgt));
    cam_soft_reset_n = 1'b1;
    expect_full();
    tgt++;
    wait_done(tgt, 600);
    check_log("soft_abort");

    // NACK every attempt on E4: four issues, error flagged, sequence continues
    done_delay = 1;
    nack_addr  = 8'h03;
    soft_pulse();
    for (int e = 0; e < 9; e++) begin
      push_entry(e);
      if (e == 4) for (int r = 0; r < 3; r++) push_entry(e);
    end
    tgt++;
    wait_done(tgt, 400);
    check_log("nack_e4");
    chk("cfg_error_set", 32'(cfg_error), 32'd1);
    nack_addr = 8'hFF;

    // Hard reset during WAIT on E1 overrides everything
    done_delay = 4;
    soft_pulse();
    push_entry(0);
    push_entry(1);
    wait_log(2, 200);
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("wait_rst_busy",      32'(busy),      32'd0);
    chk("wait_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("wait_rst_cfg_error", 32'(cfg_error), 32'd0);
    chk("wait_rst_cfg_done",  32'(cfg_done),  32'd0);
    tick(1);
    reset = 1'b0;
    expect_full();
    tgt++;
    wait_done(tgt, 600);
    check_log("reset_in_wait");

    chk("handshake_stability", 32'(stab_err), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/camera_reg_sequencer.md
CAMERA_REG_SEQUENCER -- requirements
Module: camera_reg_sequencer

Interface
REQ-001 Parameter SLAVE_ADDR, default 8'hBA: sensor I2C write address, driven on cmd_dev.
REQ-002 Parameter MAX_RETRY, default 3: re-issues allowed per entry after a NACK.
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start_row, start_column, row_size, column_size, row_mode, column_mode, exposure  in  16 each  live camera configuration values.
REQ-006 cam_soft_reset_n  in  1  low requests a full sensor re-initialisation.
REQ-007 cmd_valid  out  1  write command offered to the I2C master.
REQ-008 cmd_ready  in  1  master accepts the command when high together with cmd_valid.
REQ-009 cmd_dev  out  8  I2C device address, constant SLAVE_ADDR.
REQ-010 cmd_addr  out  8  sensor register address.
REQ-011 cmd_data  out  16  sensor register data.
REQ-012 cmd_done  in  1  one-cycle pulse: the accepted transaction has finished.
REQ-013 cmd_nack  in  1  qualified by cmd_done: the transaction was NACKed.
REQ-014 busy  out  1  high whenever the state is not IDLE.
REQ-015 cfg_done  out  1  one-cycle pulse when a sequence completes.
REQ-016 cfg_error  out  1  sticky flag: an entry was dropped after exhausting its retries.

Function
REQ-017 The entry table SHALL be fixed, with index:addr=data as follows: E0:0x0D=0x0001, E1:0x0D=0x0000, E2:0x01=start_row, E3:0x02=start_column, E4:0x03=row_size, E5:0x04=column_size, E6:0x22=row_mode, E7:0x23=column_mode, E8:0x09=exposure.
REQ-018 Shadow registers SHALL hold the last-latched value of each of E2..E8; dirty[k] SHALL be set in any cycle where input k differs from shadow k.
REQ-019 init_pending SHALL be set by reset and whenever cam_soft_reset_n is sampled low.
REQ-020 The states SHALL be IDLE, SELECT, ISSUE, WAIT and FINISH.
REQ-021 IDLE SHALL go to SELECT when cam_soft_reset_n=1 and either init_pending or any dirty bit is set.
REQ-022 Leaving IDLE with init_pending SHALL start a full sequence: clear init_pending, start at E0, and visit E0..E8 in order regardless of dirty.
REQ-023 Leaving IDLE without init_pending SHALL start an update sequence that visits only dirty entries, in ascending index order.
REQ-024 SELECT SHALL take one cycle to pick the next entry; if none remains, it SHALL go to FINISH.
REQ-025 On entry to ISSUE, cmd_addr/cmd_data SHALL be latched, the shadow SHALL be updated to the latched value, and the matching dirty bit SHALL be cleared.
REQ-026 cmd_valid SHALL be high throughout ISSUE, and cmd_addr/cmd_data SHALL stay stable until the handshake.
REQ-027 The handshake SHALL be cmd_valid & cmd_ready; it SHALL move ISSUE to WAIT, and cmd_valid SHALL be low the next cycle.
REQ-028 In WAIT, cmd_done with cmd_nack=0 SHALL advance to SELECT.
REQ-029 In WAIT, cmd_done with cmd_nack=1 SHALL return to ISSUE with the same latched command while the retry count is below MAX_RETRY; otherwise it SHALL set cfg_error and advance to SELECT.
REQ-030 The retry count SHALL be cleared whenever a new entry is selected.
REQ-031 An input that changes after its entry has been latched SHALL re-set its dirty bit and be written in a later update sequence; the in-flight command SHALL be unaffected.
REQ-032 FINISH SHALL pulse cfg_done for one cycle and return to IDLE.
REQ-033 Soft reset in SELECT or ISSUE before the handshake SHALL drop cmd_valid and return to IDLE the next cycle, with no cfg_done.
REQ-034 Soft reset in WAIT SHALL hold WAIT until cmd_done, then return to IDLE, with no cfg_done.
REQ-035 While cam_soft_reset_n=0, the block SHALL remain in IDLE.
REQ-036 On release of soft reset, the block SHALL run a full sequence.
REQ-037 cmd_done SHALL be ignored outside WAIT.

Reset
REQ-038 On reset: state=IDLE, cmd_valid=0, cmd_addr=0, cmd_data=0, busy=0, cfg_done=0, cfg_error=0, retry count=0, init_pending=1.
REQ-039 On reset, shadows SHALL load the current inputs and dirty SHALL be cleared.
REQ-040 With cam_soft_reset_n=1, the first cycle after reset deassertion SHALL leave IDLE to start a full sequence.
REQ-041 Reset SHALL override every state, including an outstanding WAIT.

Verification
REQ-042 Release reset with cmd_ready=1 and cmd_done one cycle after each handshake -> nine commands E0..E8 in order (first 0x0D/0x0001, last 0x09/exposure), then one cfg_done pulse, busy=0.
REQ-043 Idle; change exposure to 0x0400 and row_mode to 0x0011 in the same cycle -> exactly two commands, 0x22/0x0011 then 0x09/0x0400, then cfg_done.
REQ-044 NACK every attempt on E4 -> 0x03 issued 4 times, cfg_error=1, sequence continues at E5, and cfg_done still pulses.
REQ-045 Hold cmd_ready=0 for 10 cycles during ISSUE -> cmd_valid high, and addr/data constant, for all 10 cycles.
REQ-046 Drive cam_soft_reset_n low while in WAIT on E3 -> no new cmd_valid after cmd_done; return to IDLE; on release, the full sequence restarts at E0.
REQ-047 Change start_column to 0x0020 one cycle after E3's handshake -> E3 completes with the old value, and a follow-up update sequence writes 0x02/0x0020.
